// File: rtl/rv_pipe_pkg.sv
// Shared pipeline constants for the RV32I core: register index width, default
// datapath width and the layout of the packed control bundle.
package rv_pipe_pkg;

  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned CTRL_W       = 24;

  // Control bundle bit offsets (LSB of each field), shared with decoder and EX.
  localparam int unsigned CTRL_BRANCH_O     = 0;
  localparam int unsigned CTRL_JUMP_O       = 1;
  localparam int unsigned CTRL_ALU_OP_O     = 2;
  localparam int unsigned CTRL_ALU_OP_W     = 5;
  localparam int unsigned CTRL_ALU_SRC_A_O  = 7;
  localparam int unsigned CTRL_ALU_SRC_B_O  = 9;
  localparam int unsigned CTRL_MEM_RD_O     = 11;
  localparam int unsigned CTRL_MEM_WR_O     = 12;
  localparam int unsigned CTRL_MEM_SIZE_O   = 13;
  localparam int unsigned CTRL_MEM_UNSIGN_O = 16;
  localparam int unsigned CTRL_SRC_TO_REG_O = 17;
  localparam int unsigned CTRL_REG_WR_O     = 19;
  localparam int unsigned CTRL_RSVD_O       = 20;

  // Same layout as a packed struct; declared MSB first.
  typedef struct packed {
    logic [3:0]               rsvd;
    logic                     reg_wr;
    logic [1:0]               src_to_reg;
    logic                     mem_unsigned;
    logic [2:0]               mem_size;
    logic                     mem_wr;
    logic                     mem_rd;
    logic [1:0]               alu_src_b;
    logic [1:0]               alu_src_a;
    logic [CTRL_ALU_OP_W-1:0] alu_op;
    logic                     jump;
    logic                     branch;
  } ctrl_t;

endpackage

// File: rtl/wb_bypass_mux.sv
// Write-back bypass select: picks the lowest-numbered write-back port writing
// the requested register, else the fallback value. x0 is never bypassed.
module wb_bypass_mux
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEFAULT,
  parameter int unsigned NUM_WB = 2
) (
  input  logic [REG_IDX_W-1:0]        idx,
  input  logic [XLEN-1:0]             fallback,
  input  logic [NUM_WB-1:0]           wb_wr_en,
  input  logic [REG_IDX_W*NUM_WB-1:0] wb_rd,
  input  logic [XLEN*NUM_WB-1:0]      wb_data,
  output logic [XLEN-1:0]             sel_data_c
);

  // Scan oldest to youngest so port 0 overrides any other match.
  always_comb begin
    sel_data_c = fallback;
    for (int k = int'(NUM_WB) - 1; k >= 0; k--) begin
      if (wb_wr_en[k] && (wb_rd[k*REG_IDX_W +: REG_IDX_W] == idx) &&
          (idx != REG_IDX_W'(0))) begin
        sel_data_c = wb_data[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid/ready stall, flush bubble insertion and
// write-back bypass applied both at capture and while the entry is held.
module id_ex_stage_reg #(
  parameter int unsigned XLEN   = rv_pipe_pkg::XLEN_DEFAULT,
  parameter int unsigned CTRL_W = rv_pipe_pkg::CTRL_W,
  parameter int unsigned NUM_WB = 2
) (
  input  logic                                   CLK,
  input  logic                                   rst_n,
  input  logic                                   id_valid,
  output logic                                   id_ready,
  input  logic                                   flush,
  input  logic [XLEN-1:0]                        id_pc,
  input  logic [XLEN-1:0]                        id_imm,
  input  logic [CTRL_W-1:0]                      id_ctrl,
  input  logic [rv_pipe_pkg::REG_IDX_W-1:0]      id_rs1_idx,
  input  logic [rv_pipe_pkg::REG_IDX_W-1:0]      id_rs2_idx,
  input  logic [rv_pipe_pkg::REG_IDX_W-1:0]      id_rd_idx,
  input  logic [XLEN-1:0]                        id_rs1_data,
  input  logic [XLEN-1:0]                        id_rs2_data,
  input  logic [NUM_WB-1:0]                      wb_wr_en,
  input  logic [rv_pipe_pkg::REG_IDX_W*NUM_WB-1:0] wb_rd,
  input  logic [XLEN*NUM_WB-1:0]                 wb_data,
  output logic                                   ex_valid,
  input  logic                                   ex_ready,
  output logic [XLEN-1:0]                        ex_pc,
  output logic [XLEN-1:0]                        ex_imm,
  output logic [CTRL_W-1:0]                      ex_ctrl,
  output logic [rv_pipe_pkg::REG_IDX_W-1:0]      ex_rs1_idx,
  output logic [rv_pipe_pkg::REG_IDX_W-1:0]      ex_rs2_idx,
  output logic [rv_pipe_pkg::REG_IDX_W-1:0]      ex_rd_idx,
  output logic [XLEN-1:0]                        ex_rs1_data,
  output logic [XLEN-1:0]                        ex_rs2_data
);

  localparam int unsigned IDX_W = rv_pipe_pkg::REG_IDX_W;

  logic            load;
  logic            hold;
  logic [XLEN-1:0] cap_rs1;
  logic [XLEN-1:0] cap_rs2;
  logic [XLEN-1:0] held_rs1;
  logic [XLEN-1:0] held_rs2;

  // Handshake: accept whenever the slot is empty, draining, or being flushed.
  assign id_ready = !ex_valid || ex_ready || flush;
  assign load     = id_valid && id_ready && !flush;
  assign hold     = ex_valid && !ex_ready && !flush;

  wb_bypass_mux #(.XLEN(XLEN), .NUM_WB(NUM_WB)) u_cap_rs1 (
    .idx        (id_rs1_idx),
    .fallback   (id_rs1_data),
    .wb_wr_en   (wb_wr_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .sel_data_c (cap_rs1)
  );

  wb_bypass_mux #(.XLEN(XLEN), .NUM_WB(NUM_WB)) u_cap_rs2 (
    .idx        (id_rs2_idx),
    .fallback   (id_rs2_data),
    .wb_wr_en   (wb_wr_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .sel_data_c (cap_rs2)
  );

  // Held operands keep tracking write-backs so a stalled entry never goes stale.
  wb_bypass_mux #(.XLEN(XLEN), .NUM_WB(NUM_WB)) u_hold_rs1 (
    .idx        (ex_rs1_idx),
    .fallback   (ex_rs1_data),
    .wb_wr_en   (wb_wr_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .sel_data_c (held_rs1)
  );

  wb_bypass_mux #(.XLEN(XLEN), .NUM_WB(NUM_WB)) u_hold_rs2 (
    .idx        (ex_rs2_idx),
    .fallback   (ex_rs2_data),
    .wb_wr_en   (wb_wr_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .sel_data_c (held_rs2)
  );

  // Valid flop: flush wins, then load, then hold; otherwise the slot empties.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid <= 1'b1;
    end else if (!hold) begin
      ex_valid <= 1'b0;
    end
  end

  // Payload flops; contents after a drain or flush are don't-care.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc       <= XLEN'(0);
      ex_imm      <= XLEN'(0);
      ex_ctrl     <= CTRL_W'(0);
      ex_rs1_idx  <= IDX_W'(0);
      ex_rs2_idx  <= IDX_W'(0);
      ex_rd_idx   <= IDX_W'(0);
      ex_rs1_data <= XLEN'(0);
      ex_rs2_data <= XLEN'(0);
    end else if (load) begin
      ex_pc       <= id_pc;
      ex_imm      <= id_imm;
      ex_ctrl     <= id_ctrl;
      ex_rs1_idx  <= id_rs1_idx;
      ex_rs2_idx  <= id_rs2_idx;
      ex_rd_idx   <= id_rd_idx;
      ex_rs1_data <= cap_rs1;
      ex_rs2_data <= cap_rs2;
    end else if (hold) begin
      ex_rs1_data <= held_rs1;
      ex_rs2_data <= held_rs2;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: a cycle model pushes the expected EX
// state each cycle, compared one clock later against the DUT outputs.
module tb_id_ex_stage_reg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 24;
  localparam int unsigned NUM_WB = 2;

  logic              CLK;
  logic              rst_n;
  logic              id_valid;
  logic              id_ready;
  logic              flush;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic [4:0]        id_rs1_idx;
  logic [4:0]        id_rs2_idx;
  logic [4:0]        id_rd_idx;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [NUM_WB-1:0] wb_wr_en;
  logic [5*NUM_WB-1:0]    wb_rd;
  logic [XLEN*NUM_WB-1:0] wb_data;
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [4:0]        ex_rs1_idx;
  logic [4:0]        ex_rs2_idx;
  logic [4:0]        ex_rd_idx;
  logic [XLEN-1:0]   ex_rs1_data;
  logic [XLEN-1:0]   ex_rs2_data;

  id_ex_stage_reg #(.XLEN(XLEN), .CTRL_W(CTRL_W), .NUM_WB(NUM_WB)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .flush       (flush),
    .id_pc       (id_pc),
    .id_imm      (id_imm),
    .id_ctrl     (id_ctrl),
    .id_rs1_idx  (id_rs1_idx),
    .id_rs2_idx  (id_rs2_idx),
    .id_rd_idx   (id_rd_idx),
    .id_rs1_data (id_rs1_data),
    .id_rs2_data (id_rs2_data),
    .wb_wr_en    (wb_wr_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_ctrl     (ex_ctrl),
    .ex_rs1_idx  (ex_rs1_idx),
    .ex_rs2_idx  (ex_rs2_idx),
    .ex_rd_idx   (ex_rd_idx),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data)
  );

  typedef struct packed {
    logic              v;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   d1;
    logic [XLEN-1:0]   d2;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected write-back bypass: port 0 overrides port 1, x0 excluded.
  function automatic logic [XLEN-1:0] byp(input logic [4:0] idx, input logic [XLEN-1:0] fb);
    logic [XLEN-1:0] r;
    r = fb;
    if (idx != 5'd0) begin
      if (wb_wr_en[1] && wb_rd[9:5] == idx) r = wb_data[63:32];
      if (wb_wr_en[0] && wb_rd[4:0] == idx) r = wb_data[31:0];
    end
    return r;
  endfunction

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(e.v));
    if (e.v) begin
      chk({tag, ".pc"},   64'(ex_pc),       64'(e.pc));
      chk({tag, ".imm"},  64'(ex_imm),      64'(e.imm));
      chk({tag, ".ctrl"}, 64'(ex_ctrl),     64'(e.ctrl));
      chk({tag, ".rs1"},  64'(ex_rs1_idx),  64'(e.rs1));
      chk({tag, ".rs2"},  64'(ex_rs2_idx),  64'(e.rs2));
      chk({tag, ".rd"},   64'(ex_rd_idx),   64'(e.rd));
      chk({tag, ".d1"},   64'(ex_rs1_data), 64'(e.d1));
      chk({tag, ".d2"},   64'(ex_rs2_data), 64'(e.d2));
    end
  endtask

  // One clock: check id_ready, predict next EX state, compare after the edge.
  task automatic cycle(input string tag);
    exp_t nm;
    exp_t e;
    logic rdy;
    #1;
    rdy = !m.v || ex_ready || flush;
    chk({tag, ".id_ready"}, 64'(id_ready), 64'(rdy));
    nm = m;
    if (flush) begin
      nm.v = 1'b0;
    end else if (id_valid && rdy) begin
      nm.v = 1'b1;    nm.pc = id_pc;  nm.imm = id_imm; nm.ctrl = id_ctrl;
      nm.rs1 = id_rs1_idx; nm.rs2 = id_rs2_idx; nm.rd = id_rd_idx;
      nm.d1 = byp(id_rs1_idx, id_rs1_data);
      nm.d2 = byp(id_rs2_idx, id_rs2_data);
    end else if (m.v && !ex_ready) begin
      nm.d1 = byp(m.rs1, m.d1);
      nm.d2 = byp(m.rs2, m.d2);
    end else begin
      nm.v = 1'b0;
    end
    sb_q.push_back(nm);
    m = nm;
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    check_all(tag, e);
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                        input logic [31:0] d1, input logic [4:0] r2, input logic [31:0] d2);
    id_valid = v; id_pc = pc; id_imm = pc ^ 32'h0F0F_0000; id_ctrl = pc[23:0] ^ 24'hA5A5A5;
    id_rs1_idx = r1; id_rs1_data = d1; id_rs2_idx = r2; id_rs2_data = d2;
    id_rd_idx = r1 ^ r2;
  endtask

  task automatic set_wb(input logic [1:0] en, input logic [4:0] rd0, input logic [31:0] d0,
                        input logic [4:0] rd1, input logic [31:0] d1);
    wb_wr_en = en; wb_rd = {rd1, rd0}; wb_data = {d1, d0};
  endtask

  initial begin
    m = '0;
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    set_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #2;
    check_all("reset", '0);
    chk("reset.pc_zero", 64'(ex_pc), 64'h0);
    chk("reset.id_ready", 64'(id_ready), 64'h1);
    @(posedge CLK); #1;
    rst_n = 1'b1;

    // Basic capture, no write-back.
    ex_ready = 1'b1;
    set_id(1'b1, 32'h100, 5'd3, 32'h11, 5'd4, 32'h22);
    cycle("basic");
    chk("basic.rs1", 64'(ex_rs1_data), 64'h11);

    // Capture bypass with both ports hitting rd 5: port 0 wins.
    set_id(1'b1, 32'h104, 5'd5, 32'h0, 5'd5, 32'h9);
    set_wb(2'b11, 5'd5, 32'hBBBB, 5'd5, 32'hAAAA);
    cycle("cap_byp");
    chk("cap_byp.rs1", 64'(ex_rs1_data), 64'hBBBB);

    // Stall refresh: hold an entry with rs2 = 7, write rd 7 two cycles in.
    set_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_id(1'b1, 32'h200, 5'd4, 32'h66, 5'd7, 32'h55);
    cycle("stall_load");
    ex_ready = 1'b0;
    set_id(1'b1, 32'h300, 5'd9, 32'h77, 5'd10, 32'h88);
    cycle("stall_h1");
    cycle("stall_h2");
    set_wb(2'b10, 5'd0, 32'h0, 5'd7, 32'h1234);
    cycle("stall_wb");
    set_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    cycle("stall_h4");
    cycle("stall_h5");
    chk("stall.rs2", 64'(ex_rs2_data), 64'h1234);
    chk("stall.rs1", 64'(ex_rs1_data), 64'h66);
    chk("stall.pc", 64'(ex_pc), 64'h200);
    chk("stall.ready", 64'(id_ready), 64'h0);

    // Flush with id_valid and a stalled EX: bubble, nothing captured.
    flush = 1'b1;
    cycle("flush");
    chk("flush.valid", 64'(ex_valid), 64'h0);
    flush = 1'b0; id_valid = 1'b0;
    cycle("post_flush");

    // x0 guard at capture and while held.
    ex_ready = 1'b1;
    set_id(1'b1, 32'h400, 5'd0, 32'h0, 5'd0, 32'h0);
    set_wb(2'b11, 5'd0, 32'hFFFF, 5'd0, 32'hFFFF);
    cycle("x0_cap");
    chk("x0.rs1", 64'(ex_rs1_data), 64'h0);
    ex_ready = 1'b0;
    cycle("x0_hold");
    chk("x0.hold_rs2", 64'(ex_rs2_data), 64'h0);

    // Randomised traffic over a small register range to force frequent hits.
    for (int i = 0; i < 300; i++) begin
      ex_ready = ($urandom_range(0, 1) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      set_id(($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), $urandom);
      set_wb(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), $urandom);
      cycle("rand");
    end

    // Reset asserted mid-stall takes effect without a clock edge.
    flush = 1'b0; ex_ready = 1'b1;
    set_wb(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    set_id(1'b1, 32'h500, 5'd2, 32'hDEAD, 5'd6, 32'hBEEF);
    cycle("rst_load");
    ex_ready = 1'b0; id_valid = 1'b0;
    cycle("rst_hold");
    #2;
    rst_n = 1'b0;
    #1;
    m = '0;
    chk("mid_rst.valid", 64'(ex_valid), 64'h0);
    chk("mid_rst.pc", 64'(ex_pc), 64'h0);
    chk("mid_rst.d1", 64'(ex_rs1_data), 64'h0);
    chk("mid_rst.d2", 64'(ex_rs2_data), 64'h0);
    chk("mid_rst.ctrl", 64'(ex_ctrl), 64'h0);
    chk("mid_rst.rd", 64'(ex_rd_idx), 64'h0);
    chk("mid_rst.ready", 64'(id_ready), 64'h1);
    #1;
    rst_n = 1'b1;
    ex_ready = 1'b1;
    set_id(1'b1, 32'h600, 5'd1, 32'h42, 5'd2, 32'h43);
    cycle("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Parametrised ID/EX pipeline register for the pipelined RV32I core, replacing the free-running ID/EX register. It adds a valid/ready handshake (stall), a flush that inserts a bubble, and write-back bypass from NUM_WB write-back ports. Bypass applies both at capture and while an instruction is held stalled, so a held operand never goes stale. x0 is never bypassed.

## Interface
- XLEN, 32, datapath width
- CTRL_W, 24, width of packed control bundle (branch/jump/ALU/mem/src-to-reg fields, packed per rv_pipe_pkg)
- NUM_WB, 2, number of write-back bypass ports; index 0 is the youngest and has highest priority
- CLK  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a valid instruction
- id_ready  out  1  register can accept this cycle
- flush  in  1  kill held and incoming instruction
- id_pc  in  XLEN  instruction PC
- id_imm  in  XLEN  generated immediate
- id_ctrl  in  CTRL_W  packed control bundle
- id_rs1_idx, id_rs2_idx, id_rd_idx  in  5 each  register indices
- id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
- wb_wr_en  in  NUM_WB  per-port write enable
- wb_rd  in  5*NUM_WB  per-port destination; port k at bits [5k+4:5k]
- wb_data  in  XLEN*NUM_WB  per-port data; port k at bits [XLEN*k+XLEN-1:XLEN*k]
- ex_valid  out  1  EX holds a valid instruction
- ex_ready  in  1  EX consumes the instruction this cycle
- ex_pc, ex_imm  out  XLEN each
- ex_ctrl  out  CTRL_W
- ex_rs1_idx, ex_rs2_idx, ex_rd_idx  out  5 each
- ex_rs1_data, ex_rs2_data  out  XLEN each  bypass-corrected operands

## Operation
- id_ready = !ex_valid || ex_ready || flush. This is combinational. No skid entry.
- Load when id_valid && id_ready && !flush. All ex_* fields are captured. Operands pass through the bypass mux, keyed by id_rsN_idx.
- Bypass rule, per operand: select wb_data[k] for the lowest k with wb_wr_en[k] && wb_rd[k] == idx && idx != 0. Otherwise use the register-file or held value.
- Hold: when ex_valid && !ex_ready && !flush, the payload is frozen except ex_rs1_data/ex_rs2_data. Those re-apply the bypass rule each cycle, keyed by ex_rsN_idx, using the held value as fallback.
- Drain: ex_valid && ex_ready with no load gives ex_valid = 0 next cycle. The payload holds its last value and is don't-care.
- Flush has priority over everything. ex_valid = 0 next cycle, and the incoming instruction is dropped even if id_valid = 1.
- ex_ctrl is not masked on a bubble. Consumers must qualify with ex_valid.

## Timing
- Latency is 1 cycle, ID to EX.
- Bypass compares happen in the same cycle as the write-back write. The register file is write-first-invisible, hence the capture-path bypass.
- Reset, asynchronous: ex_valid = 0, and all other ex_* = 0. id_ready is 1 out of reset (since ex_valid = 0).
- Reset asserted mid-stall: the held instruction is discarded immediately.
- Simultaneous flush + ex_ready + id_valid: ex_valid = 0 next cycle.
- Simultaneous load and write-back to the same rs: the captured value is wb_data.
- Multiple ports hitting the same rd: port 0 wins.

## Structure
- rv_pipe_pkg holds:
  - REG_IDX_W = 5 and the default XLEN
  - CTRL_W and the bit offsets of each control field in the bundle, shared with the decoder and the EX stage
- Sub-module wb_bypass_mux: parameters XLEN and NUM_WB. Inputs are idx, fallback data, wb_wr_en, wb_rd and wb_data; output is the selected data. It is purely combinational and instantiated 4 times: rs1/rs2 × capture/hold.
- Top level: handshake logic, the valid flop, payload flops, and capture-versus-hold select per operand.

## Test plan
- Reset, then id_valid with rs1 = 3, data 0x11, and no write-back → next cycle ex_valid = 1, ex_rs1_data = 0x11, id_ready = 1.
- Capture bypass: id_rs1_idx = 5 with regfile data 0x0, wb port1 writing rd = 5 with 0xAAAA, and port0 writing rd = 5 with 0xBBBB in the same cycle → ex_rs1_data = 0xBBBB.
- Stall refresh:
  - Hold with ex_ready = 0 and ex_rs2_idx = 7, then write rd = 7 with 0x1234 two cycles later → ex_rs2_data = 0x1234 thereafter.
  - All other ex_* remain unchanged and id_ready = 0 throughout.
- x0 guard: idx = 0 with wb writing rd = 0, data 0xFFFF → the operand keeps its regfile value of 0.
- Flush: flush = 1 together with id_valid = 1 and ex_ready = 0 → next cycle ex_valid = 0, and no instruction is captured.
- Reset mid-stall: assert rst_n = 0 asynchronously between edges → ex_valid and all ex_* = 0 immediately.
